hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Control end of the D->E pipeline-register interface: generates stall (hold, active-high) and flush
//  (sync clear) for F/D/E/M plus forwarding selects for the E-stage ALU operands.
//  Resolves load-use, taken-branch/jump and multi-cycle data-memory waits.
//  Keeps a memory-wait timeout FSM and saturating stall/flush performance counters.
//  Sits beside the datapath; StallE_o/FlushE_o drive the D->E register's EN/CLR pins.
// PARAMETERS
//  CNT_W        32   width of StallCnt_o / FlushCnt_o (saturating)
//  MEM_TIMEOUT  64   max consecutive not-ready cycles before error (>=1)
//  LOAD_SRC     2'b01  ResultSrcE_i encoding identifying a load in E
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst          in   1      synchronous, active-high reset
//  Rs1D_i       in   5      rs1 of instruction in D
//  Rs2D_i       in   5      rs2 of instruction in D
//  Rs1E_i       in   5      rs1 of instruction in E
//  Rs2E_i       in   5      rs2 of instruction in E
//  RdE_i        in   5      rd in E
//  RdM_i        in   5      rd in M
//  RdW_i        in   5      rd in W
//  ResultSrcE_i in   2      result select of E instr (LOAD_SRC => load)
//  RegWriteM_i  in   1      M instr writes rd
//  RegWriteW_i  in   1      W instr writes rd
//  PCSrcE_i     in   1      branch taken / jump in E
//  MemReqM_i    in   1      M stage issues data-memory access
//  MemReadyM_i  in   1      data memory completes access this cycle
//  StallF_o     out  1      hold PC
//  StallD_o     out  1      hold F->D register
//  StallE_o     out  1      hold D->E register (drives its EN)
//  StallM_o     out  1      hold E->M register
//  FlushD_o     out  1      clear F->D register
//  FlushE_o     out  1      clear D->E register (drives its CLR)
//  ForwardAE_o  out  2      00 RD1E, 01 W result, 10 M ALU result
//  ForwardBE_o  out  2      same encoding for operand B
//  MemErr_o     out  1      sticky memory-timeout error
//  StallCnt_o   out  CNT_W  cycles with StallF_o=1
//  FlushCnt_o   out  CNT_W  cycles with FlushE_o=1
// BEHAVIOUR
//  Forwarding (combinational): A=10 if RegWriteM_i & RdM_i!=0 & RdM_i==Rs1E_i; else 01 if
//   RegWriteW_i & RdW_i!=0 & RdW_i==Rs1E_i; else 00. M beats W. B identical on Rs2E_i.
//  lduse = ResultSrcE_i==LOAD_SRC & RdE_i!=0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i).
//  memstall = MemReqM_i & ~MemReadyM_i (combinational, same cycle, no added latency).
//  FSM states RUN, MEM_WAIT, ERR; state, wait counter, counters reset to RUN/0/0/0.
//   RUN: memstall -> MEM_WAIT, wait_cnt<=1; else stay.
//   MEM_WAIT: MemReadyM_i|~MemReqM_i -> RUN; else wait_cnt==MEM_TIMEOUT -> ERR; else wait_cnt++.
//   ERR: stays until rst; MemErr_o=1 (registered, only in ERR).
//  Priority, highest first (outputs combinational from state + inputs):
//   1 rst=1: all stalls 0, FlushD_o=FlushE_o=1, forwards 00.
//   2 ERR or memstall: StallF/D/E/M=1, FlushD/E=0 (flush is never asserted while E is held,
//     since the D->E register ignores CLR under stall; PCSrcE_i stays held and is acted on later).
//   3 PCSrcE_i: FlushD=FlushE=1, no stalls (wrong-path D instr; overrides lduse).
//   4 lduse: StallF=StallD=1, FlushE=1 (bubble), StallE=StallM=0.
//   5 else all 0.
//  Counters: +1 per cycle on condition, saturate at all-ones, never wrap; not incremented in rst.
//  rst mid MEM_WAIT: returns to RUN next edge, wait_cnt and MemErr_o cleared.
// TESTING
//  lw x5 in E, D uses rs1=x5 -> StallF=StallD=FlushE=1 one cycle, then ForwardAE=01 next E.
//  RdM=RdW=Rs1E=3, both writing -> ForwardAE=10; RdM=0 writing -> 00 (x0 never forwarded).
//  PCSrcE=1 with lduse=1 same cycle -> FlushD=FlushE=1, StallF=StallD=0; FlushCnt +1.
//  MemReq=1, Ready low 5 cycles then high -> all stalls=1 for 5 cycles, 0 on ready; StallCnt+=5.
//  Ready held low MEM_TIMEOUT+1 cycles -> MemErr_o=1, stalls stay 1; rst -> RUN, MemErr_o=0.
//  Force counters near all-ones -> hold at all-ones under continued stalls/flushes.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: stall/flush generation, E-stage operand forwarding,
// data-memory wait timeout FSM and saturating stall/flush performance counters.
module hazard_ctrl_unit #(
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 64,
  parameter logic [1:0]  LOAD_SRC    = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D_i,
  input  logic [4:0]       Rs2D_i,
  input  logic [4:0]       Rs1E_i,
  input  logic [4:0]       Rs2E_i,
  input  logic [4:0]       RdE_i,
  input  logic [4:0]       RdM_i,
  input  logic [4:0]       RdW_i,
  input  logic [1:0]       ResultSrcE_i,
  input  logic             RegWriteM_i,
  input  logic             RegWriteW_i,
  input  logic             PCSrcE_i,
  input  logic             MemReqM_i,
  input  logic             MemReadyM_i,
  output logic             StallF_o,
  output logic             StallD_o,
  output logic             StallE_o,
  output logic             StallM_o,
  output logic             FlushD_o,
  output logic             FlushE_o,
  output logic [1:0]       ForwardAE_o,
  output logic [1:0]       ForwardBE_o,
  output logic             MemErr_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic       lduse;
  logic       memstall;
  logic [4:0] rs_e     [2];
  logic [1:0] fwd_sel  [2];
  logic       cnt_inc  [2];
  logic [CNT_W-1:0] cnt_reg [2];

  assign lduse    = (ResultSrcE_i == LOAD_SRC) && (RdE_i != 5'd0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign memstall = MemReqM_i & ~MemReadyM_i;

  assign rs_e[0] = Rs1E_i;
  assign rs_e[1] = Rs2E_i;

  // M-stage result is younger than W, so it wins when both match.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs_e[gi]))
          fwd_sel[gi] = 2'b10;
        else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs_e[gi]))
          fwd_sel[gi] = 2'b01;
      end
    end
  endgenerate

  assign ForwardAE_o = rst ? 2'b00 : fwd_sel[0];
  assign ForwardBE_o = rst ? 2'b00 : fwd_sel[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (memstall) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM_i || !MemReqM_i)
          state_next = RUN;
        else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT))
          state_next = ERR;
        else
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end
      ERR:     state_next = ERR;
      default: state_next = RUN;
    endcase
  end

  // A held D->E register ignores CLR, so flushes are suppressed while stalling.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    if (rst) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if ((state_reg == ERR) || memstall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
    end else if (PCSrcE_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (lduse) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  assign MemErr_o = (state_reg == ERR);

  assign cnt_inc[0] = StallF_o;
  assign cnt_inc[1] = FlushE_o;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && !(&cnt_reg[gi]))
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  endgenerate

  assign StallCnt_o = cnt_reg[0];
  assign FlushCnt_o = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed testbench for hazard_ctrl_unit with small counter width and timeout
// so saturation and the memory-timeout error are reachable quickly.
module tb_hazard_ctrl_unit;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 6;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic [1:0] ResultSrcE_i;
  logic RegWriteM_i, RegWriteW_i, PCSrcE_i, MemReqM_i, MemReadyM_i;
  logic StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o;
  logic [1:0] ForwardAE_o, ForwardBE_o;
  logic MemErr_o;
  logic [CNT_W-1:0] StallCnt_o, FlushCnt_o;

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  logic [5:0] ctl;
  assign ctl = {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o};

  hazard_ctrl_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst(rst),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i), .ResultSrcE_i(ResultSrcE_i),
    .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i), .PCSrcE_i(PCSrcE_i),
    .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .MemErr_o(MemErr_o), .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    Rs1D_i = 0; Rs2D_i = 0; Rs1E_i = 0; Rs2E_i = 0;
    RdE_i = 0; RdM_i = 0; RdW_i = 0; ResultSrcE_i = 2'b00;
    RegWriteM_i = 0; RegWriteW_i = 0; PCSrcE_i = 0;
    MemReqM_i = 0; MemReadyM_i = 0;
  endtask

  // Advance one clock, updating the expected saturating counters first.
  task automatic tick(input bit s, input bit f);
    if (s && exp_stall < 15) exp_stall++;
    if (f && exp_flush < 15) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    Rs1E_i = 3; RdM_i = 3; RegWriteM_i = 1; MemReqM_i = 1; PCSrcE_i = 1;
    #4;
    checks++;
    if (ctl !== 6'b000011) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000011);
    end
    checks++;
    if (ForwardAE_o !== 2'b00) begin
      failures++; $display("FAIL reset_fwd got=%b exp=00", ForwardAE_o);
    end
    @(posedge clk); #1;
    rst = 0;
    idle();
    #4;
    checks++;
    if (ctl !== 6'b000000 || MemErr_o !== 1'b0) begin
      failures++; $display("FAIL post_reset_ctl got=%b err=%b exp=000000 err=0", ctl, MemErr_o);
    end
    checks++;
    if (StallCnt_o !== 4'd0 || FlushCnt_o !== 4'd0) begin
      failures++; $display("FAIL post_reset_cnt got=%0d/%0d exp=0/0", StallCnt_o, FlushCnt_o);
    end
    $display("txn reset ctl=%b fwd=%b%b", ctl, ForwardAE_o, ForwardBE_o);
    tick(0, 0);
  endtask

  task automatic test_forwarding();
    logic [4:0] v_rdm [4] = '{5'd3, 5'd0, 5'd4, 5'd9};
    logic [4:0] v_rdw [4] = '{5'd3, 5'd0, 5'd4, 5'd9};
    logic       v_wm  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       v_ww  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] v_rs1 [4] = '{5'd3, 5'd0, 5'd1, 5'd9};
    logic [4:0] v_rs2 [4] = '{5'd7, 5'd0, 5'd4, 5'd9};
    logic [1:0] v_ea  [4] = '{2'b10, 2'b00, 2'b00, 2'b10};
    logic [1:0] v_eb  [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      idle();
      RdM_i = v_rdm[i]; RdW_i = v_rdw[i]; RegWriteM_i = v_wm[i]; RegWriteW_i = v_ww[i];
      Rs1E_i = v_rs1[i]; Rs2E_i = v_rs2[i];
      #4;
      checks++;
      if (ForwardAE_o !== v_ea[i] || ForwardBE_o !== v_eb[i]) begin
        failures++;
        $display("FAIL fwd_%0d got=%b/%b exp=%b/%b", i, ForwardAE_o, ForwardBE_o, v_ea[i], v_eb[i]);
      end
      $display("txn fwd %0d A=%b B=%b", i, ForwardAE_o, ForwardBE_o);
      tick(0, 0);
    end
  endtask

  task automatic test_load_use();
    idle();
    ResultSrcE_i = 2'b01; RdE_i = 5; Rs1D_i = 5;
    #4;
    checks++;
    if (ctl !== 6'b110001) begin
      failures++; $display("FAIL lduse_ctl got=%b exp=110001", ctl);
    end
    $display("txn lduse ctl=%b", ctl);
    tick(1, 1);
    // Dependent instr now in E, load has reached W behind the bubble.
    idle();
    Rs1E_i = 5; RdW_i = 5; RegWriteW_i = 1;
    #4;
    checks++;
    if (ForwardAE_o !== 2'b01 || ctl !== 6'b000000) begin
      failures++; $display("FAIL lduse_fwd got=%b ctl=%b exp=01 ctl=000000", ForwardAE_o, ctl);
    end
    $display("txn lduse_next fwdA=%b", ForwardAE_o);
    tick(0, 0);
  endtask

  task automatic test_branch();
    idle();
    PCSrcE_i = 1; ResultSrcE_i = 2'b01; RdE_i = 5; Rs2D_i = 5;
    #4;
    checks++;
    if (ctl !== 6'b000011) begin
      failures++; $display("FAIL branch_ctl got=%b exp=000011", ctl);
    end
    $display("txn branch ctl=%b", ctl);
    tick(0, 1);
    idle();
    #4;
    checks++;
    if (FlushCnt_o !== 4'(exp_flush) || StallCnt_o !== 4'(exp_stall)) begin
      failures++; $display("FAIL branch_cnt got=%0d/%0d exp=%0d/%0d", StallCnt_o, FlushCnt_o, exp_stall, exp_flush);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      idle();
      MemReqM_i = 1; MemReadyM_i = 0; PCSrcE_i = 1;
      #4;
      checks++;
      if (ctl !== 6'b111100 || MemErr_o !== 1'b0) begin
        failures++; $display("FAIL memwait_%0d got=%b err=%b exp=111100 err=0", i, ctl, MemErr_o);
      end
      $display("txn memwait %0d ctl=%b", i, ctl);
      tick(1, 0);
    end
    MemReadyM_i = 1;
    #4;
    checks++;
    if (ctl !== 6'b000011) begin
      failures++; $display("FAIL mem_ready got=%b exp=000011", ctl);
    end
    checks++;
    if (StallCnt_o !== 4'(exp_stall) || exp_stall != 6) begin
      failures++; $display("FAIL mem_stallcnt got=%0d exp=6", StallCnt_o);
    end
    $display("txn memready ctl=%b stallcnt=%0d", ctl, StallCnt_o);
    tick(0, 1);
    idle();
    #4;
    checks++;
    if (ctl !== 6'b000000 || MemErr_o !== 1'b0) begin
      failures++; $display("FAIL mem_run got=%b err=%b exp=000000 err=0", ctl, MemErr_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 14; i++) begin
      idle();
      ResultSrcE_i = 2'b01; RdE_i = 8; Rs2D_i = 8;
      #4;
      checks++;
      if (StallCnt_o !== 4'(exp_stall) || FlushCnt_o !== 4'(exp_flush)) begin
        failures++; $display("FAIL sat_%0d got=%0d/%0d exp=%0d/%0d", i, StallCnt_o, FlushCnt_o, exp_stall, exp_flush);
      end
      $display("txn sat %0d stall=%0d flush=%0d", i, StallCnt_o, FlushCnt_o);
      tick(1, 1);
    end
    idle();
    #4;
    checks++;
    if (StallCnt_o !== 4'hF || FlushCnt_o !== 4'hF) begin
      failures++; $display("FAIL sat_final got=%0d/%0d exp=15/15", StallCnt_o, FlushCnt_o);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      idle();
      MemReqM_i = 1; MemReadyM_i = 0;
      #4;
      checks++;
      if (MemErr_o !== 1'b0 || ctl !== 6'b111100) begin
        failures++; $display("FAIL tmo_wait_%0d err=%b ctl=%b exp err=0 ctl=111100", i, MemErr_o, ctl);
      end
      tick(1, 0);
    end
    idle();
    PCSrcE_i = 1;
    #4;
    checks++;
    if (MemErr_o !== 1'b1 || ctl !== 6'b111100) begin
      failures++; $display("FAIL tmo_err err=%b ctl=%b exp err=1 ctl=111100", MemErr_o, ctl);
    end
    $display("txn timeout err=%b ctl=%b", MemErr_o, ctl);
    tick(1, 0);
    rst = 1;
    #4;
    checks++;
    if (ctl !== 6'b000011) begin
      failures++; $display("FAIL tmo_rst_ctl got=%b exp=000011", ctl);
    end
    @(posedge clk); #1;
    rst = 0;
    idle();
    #4;
    checks++;
    if (MemErr_o !== 1'b0 || ctl !== 6'b000000 || StallCnt_o !== 4'd0 || FlushCnt_o !== 4'd0) begin
      failures++;
      $display("FAIL tmo_recover err=%b ctl=%b cnt=%0d/%0d exp err=0 ctl=000000 cnt=0/0", MemErr_o, ctl, StallCnt_o, FlushCnt_o);
    end
    $display("txn recover err=%b ctl=%b", MemErr_o, ctl);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_saturation();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
